// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
// The IF/ID bundle type is also consumed by the decode stage.
package fetch_unit_pkg;

    localparam int               WORD     = 32;
    localparam logic [WORD-1:0]  NOP      = 32'h0000_0000;
    localparam logic [WORD-1:0]  RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD-1:0] instr;
        logic [WORD-1:0] pc4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP, pc4: '0, valid: 1'b0};

    // j target: region bits come from the PC+4 of the jump itself
    function automatic logic [WORD-1:0] jump_target(input logic [3:0]  region,
                                                    input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

    function automatic logic [WORD-1:0] word_align(input logic [WORD-3:0] addr_hi);
        return {addr_hi, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: hold keeps contents, flush loads a bubble.
// Hold has priority over flush so a stalled redirect is not consumed early.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    always_comb begin
        if_id_d = if_id_q;
        if (!hold) begin
            if (flush) if_id_d = IF_ID_BUBBLE;
            else       if_id_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) if_id_q <= IF_ID_BUBBLE;
        else     if_id_q <= if_id_d;
    end

    assign q = if_id_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, redirect mux and IF/ID capture.
// Optional FETCH_STATS_EN adds fetched/flushed event counters.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [WORD-1:0] branch_target,
    input  logic            jump,
    input  logic [25:0]     jump_index,
    output logic [WORD-1:0] instr_addr,
    input  logic [WORD-1:0] instr_in,
    output logic [WORD-1:0] if_id_instr,
    output logic [WORD-1:0] if_id_pc4,
    output logic            if_id_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed
`endif
);

    logic [WORD-1:0] pc_q;
    logic [WORD-1:0] pc_d;
    logic [WORD-1:0] pc4;
    logic            redirect;
    logic            advance;
    if_id_t          if_id_in;
    if_id_t          if_id_out;
    logic            unused_branch_lsbs;

    assign pc4      = pc_q + 32'd4;
    assign redirect = jump | branch_taken;
    assign advance  = !stall && !redirect;

    assign unused_branch_lsbs = ^branch_target[1:0];

    // Jump outranks branch when the decoder raises both
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (jump)
                pc_d = jump_target(if_id_out.pc4[WORD-1:WORD-4], jump_index);
            else if (branch_taken)
                pc_d = word_align(branch_target[WORD-1:2]);
            else
                pc_d = pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    always_comb begin
        if_id_in       = IF_ID_BUBBLE;
        if_id_in.instr = instr_in;
        if_id_in.pc4   = pc4;
        if_id_in.valid = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall),
        .flush (redirect),
        .d     (if_id_in),
        .q     (if_id_out)
    );

    assign instr_addr  = pc_q;
    assign if_id_instr = if_id_out.instr;
    assign if_id_pc4   = if_id_out.pc4;
    assign if_id_valid = if_id_out.valid;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] fetched_d;
    logic [31:0] flushed_q;
    logic [31:0] flushed_d;

    always_comb begin
        fetched_d = fetched_q;
        flushed_d = flushed_q;
        if (advance)             fetched_d = fetched_q + 32'd1;
        if (!stall && redirect)  flushed_d = flushed_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed walk through the fetch scenarios,
// then randomized stall/redirect/reset traffic against a cycle-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] m_fetched, m_flushed;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .instr_addr    (instr_addr),
        .instr_in      (instr_in),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_flushed  (stat_flushed)
`endif
    );

    // combinational instruction memory: a few fixed words, hashed contents elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0020;
            32'h0000_0008: return 32'h0109_8024;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    assign instr_in = mem_word(instr_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("instr_addr",  instr_addr,          m_pc);
        chk("if_id_instr", if_id_instr,         m_instr);
        chk("if_id_pc4",   if_id_pc4,           m_pc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, m_fetched);
        chk("stat_flushed", stat_flushed, m_flushed);
`endif
    endtask

    // One clock edge: apply inputs, advance the model by the priority rules, compare.
    task automatic step(input logic r, input logic s, input logic j, input logic b,
                        input logic [31:0] bt, input logic [25:0] ji);
        rst = r; stall = s; jump = j; branch_taken = b;
        branch_target = bt; jump_index = ji;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_fetched = 0; m_flushed = 0;
        end else if (s) begin
            // everything holds
        end else if (j || b) begin
            m_pc = j ? {m_pc4[31:28], ji, 2'b00} : (bt & 32'hFFFF_FFFC);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_flushed = m_flushed + 1;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc4   = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
            m_fetched = m_fetched + 1;
        end
        #1;
        check_all();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 26'h0);
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fetched = 0; m_flushed = 0;
        // reset
        step(1, 0, 0, 0, 32'h0, 26'h0);
        step(1, 0, 0, 0, 32'h0, 26'h0);
        chk("rst_addr",  instr_addr,  32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'h0);

        // first fetch
        run_n(1);
        chk("word0", if_id_instr, 32'h2008_0020);
        chk("word0_pc4", if_id_pc4, 32'h4);
        run_n(2);
        chk("line_addr", instr_addr, 32'hC);
        chk("line_instr", if_id_instr, 32'h0109_8024);

        // stall at pc=0x10
        run_n(1);
        chk("pre_stall_addr", instr_addr, 32'h10);
        step(0, 1, 0, 0, 32'h0, 26'h0);
        step(0, 1, 1, 1, 32'h80, 26'h3); // redirect while stalled is ignored
        chk("stall_addr", instr_addr, 32'h10);
        run_n(1);
        chk("post_stall_addr", instr_addr, 32'h14);
        chk("post_stall_instr", if_id_instr, mem_word(32'h10));

        // branch at pc=0x24 to 0x4B
        run_n(4);
        chk("pre_branch_addr", instr_addr, 32'h24);
        step(0, 0, 0, 1, 32'h4B, 26'h0);
        chk("branch_addr", instr_addr, 32'h48);
        chk("branch_bubble", {31'd0, if_id_valid}, 32'h0);
        run_n(1);
        chk("branch_tgt_pc4", if_id_pc4, 32'h4C);

        // jump, then jump while stalled, then jump+branch together
        step(0, 0, 1, 0, 32'h0, 26'h1F);
        chk("jump_addr", instr_addr, 32'h7C);
        run_n(1);
        step(0, 1, 1, 0, 32'h0, 26'h2A);
        chk("jump_stalled_addr", instr_addr, 32'h80);
        step(0, 0, 1, 1, 32'h200, 26'h10);
        chk("jump_wins", instr_addr, 32'h40);

        // reset together with branch
        run_n(2);
        step(1, 0, 0, 1, 32'h300, 26'h0);
        chk("rst_br_addr", instr_addr, 32'h0);

        // PC wrap at the top of the address space
        run_n(1);
        step(0, 0, 0, 1, 32'hFFFF_FFFF, 26'h0);
        chk("wrap_top", instr_addr, 32'hFFFF_FFFC);
        run_n(1);
        chk("wrap_addr", instr_addr, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 10,
                 $urandom, 26'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
